// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient controller: FSM state type,
// default geometry and the coefficient set loaded at reset.
package fir_pkg;

    localparam int NTAPS = 9;
    localparam int CW    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_DRAIN = 2'd3
    } fir_state_e;

    // Symmetric low-pass set; element [k] is tap k (leftmost literal is tap 8).
    localparam logic [NTAPS-1:0][CW-1:0] DEFAULT_COEFFS = {
        16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
        16'h1496, 16'h1089, 16'h0AE4, 16'h04F6
    };

endpackage

// File: rtl/coeff_bank.sv
// One bank of NTAPS x CW coefficient registers: single write port, every
// tap readable at once on a flat bus (tap k at bits [k*CW +: CW]).
module coeff_bank #(
    parameter int                  NTAPS = 9,
    parameter int                  CW    = 16,
    parameter int                  IW    = $clog2(NTAPS),
    parameter logic [NTAPS*CW-1:0] INIT  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [IW-1:0]       waddr,
    input  logic [CW-1:0]       wdata,
    output logic [NTAPS*CW-1:0] rdata
);

    logic [CW-1:0] mem [NTAPS];

    // Register file: reset to the default set, otherwise write one tap per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this storage is reset on purpose -- the bank can be the
            // live filter set straight out of reset, so it must hold a known
            // valid set rather than whatever the flops power up with.
            for (int k = 0; k < NTAPS; k++) begin
                mem[k] <= INIT[k*CW +: CW];
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_rd
        assign rdata[k*CW +: CW] = mem[k];
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Double-buffered FIR coefficient loader. A stream of NTAPS coefficients
// fills the shadow bank; a correctly framed set is swapped in on the next
// sample boundary so the filter never sees a half-written set.
module fir_coeff_ctrl #(
    parameter int NTAPS = fir_pkg::NTAPS,
    parameter int CW    = fir_pkg::CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic [CW-1:0]       s_tdata,
    input  logic                s_tlast,
    input  logic                sample_en,
    output logic [NTAPS*CW-1:0] h,
    output logic                active_bank,
    output logic                swap,
    output logic                load_err,
    output logic                busy
);

    import fir_pkg::*;

    localparam int            IW       = $clog2(NTAPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

    // A single-beat set would make first and last beat coincide, which the
    // framing logic below does not handle.
    if (NTAPS < 2) begin : g_ntaps_check
        $error("fir_coeff_ctrl: NTAPS must be at least 2");
    end

    // Reset image for both banks: package defaults, sign-extended or
    // truncated to CW, zero for taps beyond the package set.
    function automatic logic [NTAPS*CW-1:0] default_set();
        logic [NTAPS*CW-1:0]           v;
        logic signed [fir_pkg::CW-1:0] c;
        v = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (k < fir_pkg::NTAPS) begin
                c = DEFAULT_COEFFS[k];
                v[k*CW +: CW] = CW'(c);
            end
        end
        return v;
    endfunction

    localparam logic [NTAPS*CW-1:0] INIT_SET = default_set();

    fir_state_e          state;
    logic [IW-1:0]       idx;
    logic                accept;
    logic                load_beat;
    logic                we0;
    logic                we1;
    logic [NTAPS*CW-1:0] rdata0;
    logic [NTAPS*CW-1:0] rdata1;

    assign s_tready  = (state != ST_ARMED);
    assign busy      = (state != ST_IDLE);
    assign accept    = s_tvalid && s_tready;
    assign load_beat = accept && (state == ST_IDLE || state == ST_LOAD);

    // Beats always land in the bank that is not driving h.
    assign we0 = load_beat &&  active_bank;
    assign we1 = load_beat && !active_bank;

    coeff_bank #(.NTAPS(NTAPS), .CW(CW), .IW(IW), .INIT(INIT_SET)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (we0),
        .waddr (idx),
        .wdata (s_tdata),
        .rdata (rdata0)
    );

    coeff_bank #(.NTAPS(NTAPS), .CW(CW), .IW(IW), .INIT(INIT_SET)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (we1),
        .waddr (idx),
        .wdata (s_tdata),
        .rdata (rdata1)
    );

    // Both banks are registers, so h changes only on the clock edge that
    // flips active_bank -- the same edge that raises swap.
    assign h = active_bank ? rdata1 : rdata0;

    // Load/arm/drain sequencing, bank selection and the one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            active_bank <= 1'b0;
            swap        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the
            // pre-edge state and idx, and the pulse defaults here are simply
            // overridden by a later assignment in the same edge.
            swap     <= 1'b0;
            load_err <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= s_tlast ? ST_ARMED : ST_DRAIN;
                        end else if (s_tlast) begin
                            // Short set: the partial shadow contents are
                            // dead; the next load overwrites every tap.
                            idx      <= '0;
                            load_err <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && s_tlast) begin
                        load_err <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (sample_en) begin
                        active_bank <= ~active_bank;
                        swap        <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: a table-driven load/arm/swap scenario
// followed by hand-written sequences for short sets, over-long sets and
// reset in the middle of a load.
module tb_fir_coeff_ctrl;

    localparam int NT = 9;
    localparam int W  = 16;

    typedef logic [W-1:0] set_t [NT];

    typedef struct {
        logic        vld;
        logic [15:0] data;
        logic        last;
        logic        se;
        logic        e_swap;
        logic        e_err;
        logic        e_busy;
        logic        e_rdy;
        logic        e_bank;
        logic        e_new;   // 0: h shows defaults, 1: h shows set A
    } vec_t;

    logic             clk;
    logic             rst;
    logic             s_tvalid;
    logic             s_tready;
    logic [W-1:0]     s_tdata;
    logic             s_tlast;
    logic             sample_en;
    logic [NT*W-1:0]  h;
    logic             active_bank;
    logic             swap;
    logic             load_err;
    logic             busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    set_t def_set, set_a, set_b, set_c, set_d, set_e;
    logic swap_seen;
    logic err_seen;

    fir_coeff_ctrl #(.NTAPS(NT), .CW(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .sample_en   (sample_en),
        .h           (h),
        .active_bank (active_bank),
        .swap        (swap),
        .load_err    (load_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [NT*W-1:0] flat(input set_t s);
        logic [NT*W-1:0] v;
        for (int k = 0; k < NT; k++) v[k*W +: W] = s[k];
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, required %0b", name, act, exp);
        end
    endtask

    task automatic check_h(input string name, input logic [NT*W-1:0] act,
                           input logic [NT*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got h=%h, required %h", name, act, exp);
        end
    endtask

    // One clock; outputs are stable and safe to sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        swap_seen = swap_seen | swap;
        err_seen  = err_seen | load_err;
    endtask

    // Present one cycle of inputs, clock it in, then return inputs to idle.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic l,
                         input logic se);
        s_tvalid  = v;
        s_tdata   = d;
        s_tlast   = l;
        sample_en = se;
        tick();
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        s_tlast   = 1'b0;
        sample_en = 1'b0;
    endtask

    task automatic add_row(input logic v, input logic [15:0] d, input logic l,
                           input logic se, input logic e_swap, input logic e_err,
                           input logic e_busy, input logic e_rdy,
                           input logic e_bank, input logic e_new);
        vec_t r;
        r = '{v, d, l, se, e_swap, e_err, e_busy, e_rdy, e_bank, e_new};
        tbl.push_back(r);
    endtask

    // Full 9-beat load of s followed by one sample_en; checks the swap.
    task automatic load_and_swap(input string tag, input set_t s,
                                 input logic exp_bank);
        for (int k = 0; k < NT; k++) drive(1'b1, s[k], k == NT - 1, 1'b0);
        check_bit({tag, "_armed_rdy"}, s_tready, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        check_bit({tag, "_swap"}, swap, 1'b1);
        check_bit({tag, "_bank"}, active_bank, exp_bank);
        check_h({tag, "_h"}, h, flat(s));
        drive(1'b0, '0, 1'b0, 1'b0);
        check_bit({tag, "_swap_off"}, swap, 1'b0);
    endtask

    initial begin
        def_set = '{16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
                    16'h1496, 16'h1089, 16'h0AE4, 16'h04F6};
        for (int k = 0; k < NT; k++) begin
            set_a[k] = 16'(16'h0111 * (k + 1));
            set_b[k] = 16'(16'h1000 + 16'h0101 * k);
            set_c[k] = 16'(16'h2000 + k);
            set_d[k] = 16'(16'h3300 + k);
            set_e[k] = 16'(16'hF000 + 16'h0010 * k);
        end
        set_a[NT-1] = 16'h0DDD;

        // Table: nine beats of set A (sample_en in mid-load and on the last
        // beat must be ignored), three idle cycles armed, then the swap.
        for (int k = 0; k < NT; k++) begin
            add_row(1'b1, set_a[k], k == NT - 1, (k == 3) || (k == NT - 1),
                    1'b0, 1'b0, 1'b1, k != NT - 1, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++)
            add_row(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_row(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        add_row(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        rst       = 1'b1;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        s_tlast   = 1'b0;
        sample_en = 1'b0;
        swap_seen = 1'b0;
        err_seen  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check_h  ("rst_h", h, flat(def_set));
        check_bit("rst_bank", active_bank, 1'b0);
        check_bit("rst_rdy", s_tready, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_swap", swap, 1'b0);
        check_bit("rst_err", load_err, 1'b0);

        // Table-driven normal load, late and same-cycle sample_en.
        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].data, tbl[i].last, tbl[i].se);
            check_bit($sformatf("row%0d_swap", i), swap, tbl[i].e_swap);
            check_bit($sformatf("row%0d_err", i), load_err, tbl[i].e_err);
            check_bit($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
            check_bit($sformatf("row%0d_rdy", i), s_tready, tbl[i].e_rdy);
            check_bit($sformatf("row%0d_bank", i), active_bank, tbl[i].e_bank);
            check_h($sformatf("row%0d_h", i), h,
                    tbl[i].e_new ? flat(set_a) : flat(def_set));
        end

        // Short set: tlast on beat 4.
        for (int k = 0; k < 4; k++) drive(1'b1, set_b[k], k == 3, 1'b0);
        check_bit("short_err", load_err, 1'b1);
        check_bit("short_busy", busy, 1'b0);
        check_h  ("short_h", h, flat(set_a));
        check_bit("short_bank", active_bank, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        check_bit("short_err_off", load_err, 1'b0);
        check_bit("short_no_swap", swap, 1'b0);
        load_and_swap("short_reload", set_b, 1'b0);

        // Over-long set: 12 beats, tlast on beat 12.
        swap_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, (k < NT) ? set_c[k] : 16'(16'hBAD0 + k), k == 11, 1'b0);
            if (k == NT - 1) begin
                check_bit("long_drain_busy", busy, 1'b1);
                check_bit("long_drain_rdy", s_tready, 1'b1);
                check_bit("long_drain_err", load_err, 1'b0);
            end
        end
        check_bit("long_err", load_err, 1'b1);
        check_bit("long_busy", busy, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        check_bit("long_err_off", load_err, 1'b0);
        check_bit("long_no_swap", swap_seen, 1'b0);
        check_bit("long_bank", active_bank, 1'b0);
        check_h  ("long_h", h, flat(set_b));

        // Reset after beat 5 of a load.
        swap_seen = 1'b0;
        err_seen  = 1'b0;
        for (int k = 0; k < 5; k++) drive(1'b1, set_d[k], 1'b0, 1'b0);
        check_bit("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_h  ("midrst_h", h, flat(def_set));
        check_bit("midrst_bank", active_bank, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_rdy", s_tready, 1'b1);
        check_bit("midrst_no_swap", swap_seen, 1'b0);
        check_bit("midrst_no_err", err_seen, 1'b0);
        load_and_swap("midrst_reload", set_e, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 9, number of FIR taps.
REQ-002 SHALL have parameter CW, default 16, signed coefficient width.
REQ-003 SHALL have port clk  input  1  single clock; FIR sample-rate domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_tvalid  input  1  coefficient beat valid.
REQ-006 SHALL have port s_tready  output  1  coefficient beat accepted when high with s_tvalid.
REQ-007 SHALL have port s_tdata  input  CW  coefficient, tap 0 first.
REQ-008 SHALL have port s_tlast  input  1  final coefficient of a set.
REQ-009 SHALL have port sample_en  input  1  one-cycle strobe at FIR sample boundary.
REQ-010 SHALL have port h  output  NTAPS*CW  active coefficient set, tap k at bits [k*CW +: CW].
REQ-011 SHALL have port active_bank  output  1  index of bank driving h.
REQ-012 SHALL have port swap  output  1  one-cycle pulse, new set applied.
REQ-013 SHALL have port load_err  output  1  one-cycle pulse, malformed set discarded.
REQ-014 SHALL have port busy  output  1  high while not IDLE.

Function
REQ-015 SHALL hold two banks of NTAPS x CW registers; h is the active bank and is registered, never combinational from s_tdata.
REQ-016 SHALL implement states IDLE, LOAD, ARMED, DRAIN.
REQ-017 s_tready SHALL be 1 in IDLE, LOAD and DRAIN, and 0 in ARMED.
REQ-018 An accepted beat in IDLE or LOAD SHALL write the shadow bank at tap index idx, then increment idx; IDLE->LOAD on the first beat, idx starts at 0.
REQ-019 An accepted beat at idx=NTAPS-1 with s_tlast=1 SHALL go to ARMED.
REQ-020 An accepted beat with s_tlast=1 and idx<NTAPS-1 SHALL pulse load_err the next cycle, discard the shadow contents, and go to IDLE with idx=0.
REQ-021 An accepted beat at idx=NTAPS-1 with s_tlast=0 SHALL go to DRAIN.
REQ-022 In DRAIN, beats SHALL be accepted and ignored; the beat with s_tlast=1 SHALL pulse load_err and go to IDLE.
REQ-023 In ARMED, the first sample_en SHALL toggle active_bank, go to IDLE, and pulse swap in the same cycle that h changes.
REQ-024 sample_en outside ARMED SHALL have no effect, including the cycle the final beat is accepted; the earliest swap is one cycle after entry to ARMED.
REQ-025 When a single-beat set (NTAPS=1 special case) is not supported, NTAPS SHALL be at least 2.
REQ-026 h SHALL never show a partially written set; the shadow bank is never the active bank.

Reset
REQ-027 rst SHALL force IDLE, idx=0, active_bank=0, swap=0, load_err=0, busy=0, and s_tready=1 in the cycle after release.
REQ-028 rst SHALL load both banks with DEFAULT_COEFFS from the package (0x04F6, 0x0AE4, 0x1089, 0x1496, 0x160F, 0x1496, 0x1089, 0x0AE4, 0x04F6), so h is valid immediately after reset.
REQ-029 rst asserted mid-LOAD, mid-DRAIN or in ARMED SHALL abandon the transfer without pulsing swap or load_err.

Structure
REQ-030 Package fir_pkg SHALL hold the state enum type, CW, NTAPS and DEFAULT_COEFFS.
REQ-031 Sub-module coeff_bank (NTAPS x CW register file with a write port and a flat read port) SHALL be instantiated twice.

Verification
REQ-032 Reset -> h equals DEFAULT_COEFFS, active_bank=0, s_tready=1, busy=0.
REQ-033 Load 9 beats 0x0111..0x0DDD with tlast on beat 9, then pulse sample_en 3 cycles later -> swap for 1 cycle, h equals the new set, active_bank=1; h is unchanged before sample_en.
REQ-034 Pulse sample_en in the same cycle as the last beat -> no swap; the next sample_en swaps.
REQ-035 Send tlast on beat 4 -> load_err pulse, h unchanged, state IDLE; a following valid 9-beat load swaps correctly.
REQ-036 Send 12 beats with tlast on beat 12 -> beats 10-12 ignored, load_err on beat 12, no swap.
REQ-037 Assert rst after beat 5 of a load -> h equals DEFAULT_COEFFS, no swap or load_err pulse, and a fresh load succeeds.
